// File: rtl/dqn_train_scheduler_if.sv
// -----------------------------------------------------------------------------
// dqn_train_scheduler_if
// Bundles the handshake signals of the DQN training scheduler: the episode
// start from the top-level FSM, the replay-memory read port and the ANN
// sample/backprop/target-update handshake.
//   master : environment side (drives i_*, observes o_*)
//   slave  : scheduler side   (observes i_*, drives o_*)
// -----------------------------------------------------------------------------
interface dqn_train_scheduler_if #(
    parameter int MEMORY_ADDR_WIDTH = 14,
    parameter int UPDATE_PERIOD     = 4
);
    logic                                 i_start;
    logic [MEMORY_ADDR_WIDTH:0]           i_mem_count;
    logic                                 i_rd_valid;
    logic                                 i_main_net_done;
    logic                                 i_update_done;
    logic                                 o_rd_en;
    logic [MEMORY_ADDR_WIDTH-1:0]         o_rd_addr;
    logic                                 o_sample_valid;
    logic                                 o_update_request;
    logic                                 o_train_mode;
    logic                                 o_train_done;
    logic [$clog2(UPDATE_PERIOD+1)-1:0]   o_batch_cnt;

    modport master (
        output i_start, i_mem_count, i_rd_valid, i_main_net_done, i_update_done,
        input  o_rd_en, o_rd_addr, o_sample_valid, o_update_request,
               o_train_mode, o_train_done, o_batch_cnt
    );

    modport slave (
        input  i_start, i_mem_count, i_rd_valid, i_main_net_done, i_update_done,
        output o_rd_en, o_rd_addr, o_sample_valid, o_update_request,
               o_train_mode, o_train_done, o_batch_cnt
    );
endinterface

// File: rtl/dqn_train_scheduler.sv
// -----------------------------------------------------------------------------
// dqn_train_scheduler
// Runs one DQN training batch per finished episode: draws replay-memory
// addresses, issues one read per sample, hands each sample to the ANN, waits
// for its backprop, and requests a target-network update every UPDATE_PERIOD
// batches.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, ACTIVE HIGH (name kept for codebase reasons)
//   bus    : dqn_train_scheduler_if.slave
//            i_start, i_mem_count          episode-done / replay fill level
//            o_rd_en, o_rd_addr, i_rd_valid  replay read port
//            o_sample_valid, i_main_net_done ANN sample handshake
//            o_update_request, i_update_done target-network update handshake
//            o_train_mode, o_train_done, o_batch_cnt status
//
// Build option:
//   DQN_TRAIN_SCHED_SEQ_ADDR_EN - addresses come from a wrapping sequential
//   counter instead of LFSR rejection sampling.
//
// All outputs are registered from the next-state value, so each strobe is
// high exactly during the cycle the FSM sits in the matching state.
// -----------------------------------------------------------------------------
module dqn_train_scheduler #(
    parameter int          MEMORY_ADDR_WIDTH = 14,
    parameter int          BATCH_SIZE        = 128,
    parameter int          UPDATE_PERIOD     = 4,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dqn_train_scheduler_if.slave   bus
);
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int CW = MEMORY_ADDR_WIDTH + 1;
    localparam int SW = $clog2(BATCH_SIZE + 1);
    localparam int BW = $clog2(UPDATE_PERIOD + 1);

    localparam logic [CW-1:0] ADDR_SPACE  = {1'b1, {AW{1'b0}}};
    localparam logic [31:0]   BATCH_U     = BATCH_SIZE;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(BATCH_SIZE - 1);
    localparam logic [BW-1:0] LAST_BATCH  = BW'(UPDATE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_ISSUE, S_WAIT_RD, S_WAIT_NET, S_BATCH_END, S_UPDATE, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_lat_q, cnt_lat_d;
    logic [SW-1:0]   sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]   batch_cnt_q, batch_cnt_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            rd_en_q, rd_en_d;
    logic            sample_valid_q, sample_valid_d;
    logic            update_req_q, update_req_d;
    logic            train_mode_q, train_mode_d;
    logic            train_done_q, train_done_d;

    logic [CW-1:0]   cnt_cap;
    logic            skip;
    logic [AW-1:0]   cand;
    logic            cand_ok;

    // The latched count is only meaningful up to the address space size.
    assign cnt_cap = (cnt_lat_q > ADDR_SPACE) ? ADDR_SPACE : cnt_lat_q;
    // The skip decision reads the latched count, so it is taken in the first
    // GEN cycle; a too-small memory therefore leaves GEN for DONE at once.
    assign skip    = 32'(cnt_lat_q) < BATCH_U;

`ifdef DQN_TRAIN_SCHED_SEQ_ADDR_EN
    logic [AW-1:0] seq_addr_q, seq_addr_d;

    assign cand    = seq_addr_q;
    assign cand_ok = 1'b1;

    always_comb begin
        seq_addr_d = seq_addr_q;
        if (state_q == S_GEN && !skip) begin
            if ({1'b0, seq_addr_q} + CW'(1) >= cnt_cap) seq_addr_d = '0;
            else                                         seq_addr_d = seq_addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) seq_addr_q <= '0;
        else       seq_addr_q <= seq_addr_d;
    end
`else
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr_q, lfsr_d;

    assign cand    = lfsr_q[AW-1:0];
    // Rejection sampling: only addresses inside the filled region are taken.
    assign cand_ok = ({1'b0, cand} < cnt_cap);

    // Fibonacci taps 16,14,13,11; one step per GEN cycle, accepted or not.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_GEN)
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst_n) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_lat_d    = cnt_lat_q;
        sample_cnt_d = sample_cnt_q;
        batch_cnt_d  = batch_cnt_q;
        rd_addr_d    = rd_addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    cnt_lat_d    = bus.i_mem_count;
                    sample_cnt_d = '0;
                    state_d      = S_GEN;
                end
            end
            S_GEN: begin
                if (skip) begin
                    state_d = S_DONE;
                end else if (cand_ok) begin
                    rd_addr_d = cand;
                    state_d   = S_ISSUE;
                end
            end
            // A read response already in the strobe cycle is taken directly.
            S_ISSUE:   state_d = bus.i_rd_valid ? S_WAIT_NET : S_WAIT_RD;
            S_WAIT_RD: if (bus.i_rd_valid) state_d = S_WAIT_NET;
            S_WAIT_NET: begin
                if (bus.i_main_net_done) begin
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        state_d = S_BATCH_END;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                        state_d      = S_GEN;
                    end
                end
            end
            S_BATCH_END: begin
                if (batch_cnt_q == LAST_BATCH) begin
                    batch_cnt_d = '0;
                    state_d     = S_UPDATE;
                end else begin
                    batch_cnt_d = batch_cnt_q + BW'(1);
                    state_d     = S_DONE;
                end
            end
            S_UPDATE: if (bus.i_update_done) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered.
        rd_en_d        = (state_d == S_ISSUE);
        sample_valid_d = (state_d == S_WAIT_NET) && (state_q != S_WAIT_NET);
        update_req_d   = (state_d == S_UPDATE)   && (state_q != S_UPDATE);
        train_done_d   = (state_d == S_DONE);
        train_mode_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= S_IDLE;
            cnt_lat_q      <= '0;
            sample_cnt_q   <= '0;
            batch_cnt_q    <= '0;
            rd_addr_q      <= '0;
            rd_en_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            update_req_q   <= 1'b0;
            train_mode_q   <= 1'b0;
            train_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_lat_q      <= cnt_lat_d;
            sample_cnt_q   <= sample_cnt_d;
            batch_cnt_q    <= batch_cnt_d;
            rd_addr_q      <= rd_addr_d;
            rd_en_q        <= rd_en_d;
            sample_valid_q <= sample_valid_d;
            update_req_q   <= update_req_d;
            train_mode_q   <= train_mode_d;
            train_done_q   <= train_done_d;
        end
    end

    assign bus.o_rd_en          = rd_en_q;
    assign bus.o_rd_addr        = rd_addr_q;
    assign bus.o_sample_valid   = sample_valid_q;
    assign bus.o_update_request = update_req_q;
    assign bus.o_train_mode     = train_mode_q;
    assign bus.o_train_done     = train_done_q;
    assign bus.o_batch_cnt      = batch_cnt_q;

endmodule

// File: tb/tb_dqn_train_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dqn_train_scheduler
// Drives directed and randomized training batches through the scheduler and
// compares every strobe, address and latency against a reference model kept
// as plain arithmetic: an LFSR word, a sequential address counter and a batch
// counter. Build option DQN_TRAIN_SCHED_SEQ_ADDR_EN switches the model to
// sequential addressing together with the design.
// -----------------------------------------------------------------------------
module tb_dqn_train_scheduler;
    localparam int          AW   = 4;
    localparam int          B    = 4;
    localparam int          U    = 2;
    localparam logic [15:0] SEED = 16'hACEF;   // first candidate 15: rejected when count is 5

    logic clk = 1'b0;
    logic rst_n;

    dqn_train_scheduler_if #(.MEMORY_ADDR_WIDTH(AW), .UPDATE_PERIOD(U)) ifc ();

    dqn_train_scheduler #(
        .MEMORY_ADDR_WIDTH (AW),
        .BATCH_SIZE        (B),
        .UPDATE_PERIOD     (U),
        .LFSR_SEED         (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Pulse counters, sampled mid-cycle.
    int n_rd = 0, n_sv = 0, n_upd = 0, n_done = 0;
    always @(negedge clk) begin
        if (ifc.o_rd_en)          n_rd++;
        if (ifc.o_sample_valid)   n_sv++;
        if (ifc.o_update_request) n_upd++;
        if (ifc.o_train_done)     n_done++;
    end

    // Reference model state.
    logic [15:0] m_lfsr;
    int          m_seq;
    int          m_batch;
    int          e_rd = 0, e_sv = 0, e_upd = 0, e_done = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    function automatic int cap(input int cnt);
        return (cnt > 2**AW) ? 2**AW : cnt;
    endfunction

    task automatic m_reset();
        m_lfsr  = SEED;
        m_seq   = 0;
        m_batch = 0;
    endtask

    // Next address and the number of GEN cycles spent finding it.
    task automatic model_pick(input int cnt, output int addr, output int gens);
`ifdef DQN_TRAIN_SCHED_SEQ_ADDR_EN
        addr  = m_seq;
        gens  = 1;
        m_seq = (m_seq + 1 >= cap(cnt)) ? 0 : m_seq + 1;
`else
        logic [15:0] cur;
        gens = 0;
        do begin
            cur    = m_lfsr;
            addr   = int'(cur[AW-1:0]);
            m_lfsr = lfsr_next(m_lfsr);
            gens++;
        end while (addr >= cap(cnt));
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        ifc.i_start         = 1'b0;
        ifc.i_rd_valid      = 1'b0;
        ifc.i_main_net_done = 1'b0;
        ifc.i_update_done   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"},  32'(ifc.o_rd_en), 0);
        chk({tag, "_addr"},   32'(ifc.o_rd_addr), 0);
        chk({tag, "_sv"},     32'(ifc.o_sample_valid), 0);
        chk({tag, "_upd"},    32'(ifc.o_update_request), 0);
        chk({tag, "_mode"},   32'(ifc.o_train_mode), 0);
        chk({tag, "_done"},   32'(ifc.o_train_done), 0);
        chk({tag, "_bcnt"},   32'(ifc.o_batch_cnt), 0);
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        m_reset();
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_n_rd"},   n_rd,   e_rd);
        chk({tag, "_n_sv"},   n_sv,   e_sv);
        chk({tag, "_n_upd"},  n_upd,  e_upd);
        chk({tag, "_n_done"}, n_done, e_done);
    endtask

    // One batch: rd/net/upd delays in cycles, stray = inject ignored events,
    // abort_at = sample index whose WAIT_NET gets a reset (-1 for none).
    task automatic run_batch(input int cnt, input int rd_dly, input int net_dly,
                             input int upd_dly, input bit stray, input int abort_at);
        int  addr, gens, k;
        bit  upd;
        ifc.i_mem_count = (AW+1)'(cnt);
        ifc.i_start     = 1'b1;
        tick();                                   // first GEN cycle
        ifc.i_start     = 1'b0;
        ifc.i_mem_count = (AW+1)'($urandom_range(0, 31));   // must not matter now
        chk("mode_gen", 32'(ifc.o_train_mode), 1);

        if (cnt < B) begin
`ifndef DQN_TRAIN_SCHED_SEQ_ADDR_EN
            m_lfsr = lfsr_next(m_lfsr);           // the single GEN cycle still steps
`endif
            tick();
            chk("skip_done", 32'(ifc.o_train_done), 1);
            chk("skip_mode", 32'(ifc.o_train_mode), 0);
            e_done++;
            tick();
            chk("skip_done_w", 32'(ifc.o_train_done), 0);
            chk("skip_bcnt", 32'(ifc.o_batch_cnt), 32'(m_batch));
            chk_counts("skip");
            return;
        end

        for (int s = 0; s < B; s++) begin
            model_pick(cnt, addr, gens);
            k = 0;
            do begin
                tick();
                k++;
            end while (!ifc.o_rd_en && k < 200);
            if (!ifc.o_rd_en) begin
                chk("rd_en_timeout", 0, 1);
                do_reset();
                return;
            end
            e_rd++;
            chk("rd_lat", k, gens);
            chk("rd_addr", 32'(ifc.o_rd_addr), 32'(addr));
            chk("mode_issue", 32'(ifc.o_train_mode), 1);

            for (int d = 0; d < rd_dly; d++) begin
                tick();
                ifc.i_main_net_done = stray && (d == 0);   // ignored in WAIT_RD
            end
            ifc.i_rd_valid = 1'b1;
            tick();
            ifc.i_rd_valid      = 1'b0;
            ifc.i_main_net_done = 1'b0;
            chk("sv", 32'(ifc.o_sample_valid), 1);
            chk("addr_hold", 32'(ifc.o_rd_addr), 32'(addr));
            e_sv++;

            if (abort_at == s) begin
                rst_n = 1'b1;
                tick();
                rst_n = 1'b0;
                m_reset();
                chk_all_zero("abort");
                for (int d = 0; d < 6; d++) tick();
                chk_counts("abort");
                return;
            end

            for (int d = 0; d < net_dly; d++) begin
                ifc.i_start = stray && (d == 0);           // ignored outside IDLE
                tick();
                chk("mode_wait", 32'(ifc.o_train_mode), 1);
            end
            ifc.i_start         = 1'b0;
            ifc.i_main_net_done = 1'b1;
            tick();
            ifc.i_main_net_done = 1'b0;
        end

        // BATCH_END cycle
        chk("be_done", 32'(ifc.o_train_done), 0);
        chk("be_mode", 32'(ifc.o_train_mode), 1);
        upd     = (m_batch == U - 1);
        m_batch = upd ? 0 : m_batch + 1;
        tick();
        if (upd) begin
            chk("upd_req", 32'(ifc.o_update_request), 1);
            chk("upd_done_early", 32'(ifc.o_train_done), 0);
            e_upd++;
            for (int d = 0; d < upd_dly; d++) begin
                tick();
                chk("upd_mode", 32'(ifc.o_train_mode), 1);
            end
            ifc.i_update_done = 1'b1;
            tick();
            ifc.i_update_done = 1'b0;
        end else begin
            chk("no_upd_req", 32'(ifc.o_update_request), 0);
        end
        chk("done", 32'(ifc.o_train_done), 1);
        chk("done_mode", 32'(ifc.o_train_mode), 0);
        e_done++;
        tick();
        chk("idle_done", 32'(ifc.o_train_done), 0);
        chk("bcnt", 32'(ifc.o_batch_cnt), 32'(m_batch));
        chk_counts("batch");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        clr_inputs();
        ifc.i_mem_count = '0;
        rst_n = 1'b1;
        m_reset();
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b0;
        tick();

        run_batch(3, 0, 0, 0, 1'b0, -1);          // skipped batch
        run_batch(16, 2, 5, 0, 1'b0, -1);         // full batch, no update
        run_batch(16, 2, 5, 10, 1'b0, -1);        // update cadence
        do_reset();
        tick();
        run_batch(5, 1, 2, 0, 1'b0, -1);          // rejection from the seed
        run_batch(16, 3, 3, 1, 1'b1, -1);         // ignored events
        run_batch(16, 0, 0, 0, 1'b0, -1);         // zero-delay responses
        run_batch(16, 1, 1, 0, 1'b0, 1);          // reset in WAIT_NET of sample 2
        run_batch(6, 1, 0, 0, 1'b0, -1);
        run_batch(6, 0, 1, 0, 1'b0, -1);

        for (int i = 0; i < 25; i++) begin
            cnt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, B - 1) : $urandom_range(B, 31);
            run_batch(cnt, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
